// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs MIPS instruction fields into R/I/J words and
// writes them sequentially into instruction memory, one word per 3 cycles.
// Optional macro ENC_CHECK_EN: reject illegal bundles (fmt==0 with nonzero
// opcode, or fmt==3) without writing, and raise a sticky err flag.
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        func,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          fmt_q, fmt_d;
  logic [5:0]          opcode_q, opcode_d, func_q, func_d;
  logic [4:0]          rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
  logic [15:0]         imm_q, imm_d;
  logic [25:0]         target_q, target_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     cnt_q, cnt_d, cnt_inc;
  logic                full_q, full_d;
  logic [31:0]         enc;
  logic                illegal;
`ifdef ENC_CHECK_EN
  logic                err_q, err_d;
`endif

  // Pack the captured fields according to the captured format.
  always_comb begin
    enc = 32'h0;
    case (fmt_q)
      2'd0:    enc = {opcode_q, rs_q, rt_q, rd_q, shamt_q, func_q};
      2'd1:    enc = {opcode_q, rs_q, rt_q, imm_q};
      2'd2:    enc = {opcode_q, target_q};
      default: enc = {opcode_q, 26'b0};
    endcase
  end

`ifdef ENC_CHECK_EN
  assign illegal = ((fmt_q == 2'd0) && (opcode_q != 6'd0)) || (fmt_q == 2'd3);
  assign err     = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  assign cnt_inc    = cnt_q + 1'b1;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = cnt_q;
  assign full       = full_q;

  // Next-state, handshake and write-strobe decode.
  always_comb begin
    state_d  = state_q;
    fmt_d    = fmt_q;
    opcode_d = opcode_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    shamt_d  = shamt_q;
    func_d   = func_q;
    imm_d    = imm_q;
    target_d = target_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
`ifdef ENC_CHECK_EN
    err_d    = err_q;
`endif
    in_ready = (state_q == IDLE) && !reset;
    mem_we   = (state_q == WRITE) && !reset;
    done     = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          fmt_d    = fmt;
          opcode_d = opcode;
          rs_d     = rs;
          rt_d     = rt;
          rd_d     = rd;
          shamt_d  = shamt;
          func_d   = func;
          imm_d    = imm;
          target_d = target;
          last_d   = in_last;
          state_d  = ENCODE;
        end
      end
      ENCODE: begin
        if (illegal) begin
`ifdef ENC_CHECK_EN
          err_d = 1'b1;
`endif
          state_d = last_q ? DONE : IDLE;
        end else begin
          wdata_d = enc;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_inc;
        // Depth check runs even on the last word so full reports a
        // session that filled exactly at its final bundle.
        if (cnt_inc == DEPTH_C) full_d = 1'b1;
        if (last_q || (cnt_inc == DEPTH_C)) state_d = DONE;
        else state_d = IDLE;
      end
      DONE: begin
        if (start) begin
          cnt_d   = '0;
          addr_d  = BASE_C;
          full_d  = 1'b0;
`ifdef ENC_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      fmt_q    <= '0;
      opcode_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      shamt_q  <= '0;
      func_q   <= '0;
      imm_q    <= '0;
      target_q <= '0;
      last_q   <= 1'b0;
      addr_q   <= BASE_C;
      wdata_q  <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
`ifdef ENC_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fmt_q    <= fmt_d;
      opcode_q <= opcode_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      shamt_q  <= shamt_d;
      func_q   <= func_d;
      imm_q    <= imm_d;
      target_q <= target_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
`ifdef ENC_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader (DEPTH=4 to reach the full case).
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, in_last;
  logic [1:0]  fmt;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        mem_we, done, full, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [7:0] we_addr[$];

  instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .fmt(fmt), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func), .imm(imm),
    .target(target), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count), .done(done),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Log every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      we_addr.push_back(mem_addr);
      we_cnt++;
    end
  end

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
    logic [31:0] exp_w;
    logic [7:0]  exp_a;
    logic [8:0]  exp_c;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
    shamt = v.sh; func = v.fn; imm = v.imm; target = v.tgt; in_last = v.last;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'b0, in_ready}, 32'd1);
  endtask

  // Handshake one bundle and check the N+1 / N+2 / N+3 timing of the write.
  task automatic send(input vec_t v);
    wait_ready();
    drive(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("encode_we", {31'b0, mem_we}, 32'd0);
    chk("encode_rdy", {31'b0, in_ready}, 32'd0);
    tick();
    chk("write_we", {31'b0, mem_we}, 32'd1);
    chk("write_addr", {24'b0, mem_addr}, {24'b0, v.exp_a});
    chk("write_data", mem_wdata, v.exp_w);
    tick();
    chk("after_we", {31'b0, mem_we}, 32'd0);
    chk("count", {23'b0, word_count}, {23'b0, v.exp_c});
    chk("err_clear", {31'b0, err}, 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_addr", {24'b0, mem_addr}, 32'd0);
    chk("start_cnt", {23'b0, word_count}, 32'd0);
    chk("start_done", {30'b0, done, full}, 32'd0);
    chk("start_rdy", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    int wc0;
    // fmt op rs rt rd sh fn imm tgt last exp_w exp_a exp_c
    tbl[0] = '{2'd0, 6'h00, 5'd2, 5'd3, 5'd1, 5'd0, 6'h20, 16'hBEEF, 26'h3FFFFFF, 1'b0, 32'h00430820, 8'h00, 9'd1};
    tbl[1] = '{2'd1, 6'h23, 5'd9, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004, 26'h155AAAA, 1'b0, 32'h8D280004, 8'h01, 9'd2};
    tbl[2] = '{2'd2, 6'h02, 5'd7, 5'd7, 5'd7, 5'd7, 6'h11, 16'h1234, 26'h0100000, 1'b1, 32'h08100000, 8'h02, 9'd3};
    tbl[3] = '{2'd0, 6'h00, 5'd0, 5'd5, 5'd4, 5'd3, 6'h00, 16'hFFFF, 26'h0, 1'b0, 32'h000520C0, 8'h00, 9'd1};
    tbl[4] = '{2'd1, 6'h08, 5'd9, 5'd8, 5'd1, 5'd2, 6'h2A, 16'hFFFF, 26'h2AAAAAA, 1'b1, 32'h2128FFFF, 8'h01, 9'd2};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    drive(tbl[0]); in_last = 1'b0;
    tick();
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("rst_outs", {mem_we, done, full, err, 28'b0}, 32'd0);
    chk("rst_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_cnt", {23'b0, word_count}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", {31'b0, in_ready}, 32'd1);

    // Two sessions from the table; each ends on its last bundle.
    for (int i = 0; i < 5; i++) begin
      send(tbl[i]);
      if (tbl[i].last) begin
        chk("last_done", {30'b0, done, full}, 32'd2);
        chk("last_rdy", {31'b0, in_ready}, 32'd0);
        wc0 = we_cnt;
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("done_ignore", we_cnt, wc0);
        chk("done_rdy", {31'b0, in_ready}, 32'd0);
        pulse_start();
      end
    end

    // Stream with valid held: DEPTH=4 words, then full and done.
    wc0 = we_cnt;
    drive(tbl[0]); in_last = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 18; k++) tick();
    in_valid = 1'b0;
    chk("stream_pulses", we_cnt - wc0, 32'd4);
    for (int k = 0; k < 4; k++)
      if (wc0 + k < we_addr.size())
        chk("stream_addr", {24'b0, we_addr[wc0+k]}, k);
    chk("stream_full", {30'b0, done, full}, 32'd3);
    chk("stream_cnt", {23'b0, word_count}, 32'd4);
    chk("stream_rdy", {31'b0, in_ready}, 32'd0);

    // Reset while a word is in ENCODE.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    send(tbl[0]);
    wc0 = we_cnt;
    drive(tbl[1]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_rdy", {31'b0, in_ready}, 32'd0);
    chk("midrst_addr", {24'b0, mem_addr}, 32'd0);
    chk("midrst_cnt", {23'b0, word_count}, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_flags", {29'b0, done, full, err}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_nowrite", we_cnt, wc0);
    v = tbl[1]; v.exp_a = 8'h00; v.exp_c = 9'd1;
    send(v);

`ifdef ENC_CHECK_EN
    // Illegal R bundle: no write, err set, address held.
    wc0 = we_cnt;
    v = tbl[0]; v.op = 6'h08;
    drive(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("ill_nowrite", we_cnt, wc0);
    chk("ill_err", {31'b0, err}, 32'd1);
    chk("ill_addr", {24'b0, mem_addr}, 32'd1);
    chk("ill_cnt", {23'b0, word_count}, 32'd1);
    chk("ill_rdy", {31'b0, in_ready}, 32'd1);
    wait_ready();
    drive(tbl[1]); in_last = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ill_next_we", {31'b0, mem_we}, 32'd1);
    chk("ill_next_addr", {24'b0, mem_addr}, 32'd1);
    chk("ill_next_data", mem_wdata, 32'h8D280004);
    tick();
    chk("ill_sticky", {31'b0, err}, 32'd1);
`else
    // Raw format: opcode only, everything else zero.
    v = '{2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'hFC000000, 8'h01, 9'd2};
    send(v);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Writer-side counterpart of the decode stage.
- Accepts MIPS instruction fields over a valid/ready handshake and packs them into 32-bit R/I/J-format words.
- Writes each packed word sequentially into instruction memory through a single-cycle write port.
- Used by the bench and boot path to fill instruction memory before the multi-cycle processor leaves reset.

Parameters:
- ADDR_W, 8, width of the instruction memory word address.
- BASE_ADDR, 0, first word address written after reset or restart.
- DEPTH, 256, maximum words written per load session. Must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; restarts a session from DONE.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block accepts a bundle this cycle.
- in_last  input  1  bundle is the final word of the session.
- fmt  input  2  0=R, 1=I, 2=J, 3=raw-opcode.
- opcode  input  6  instruction[31:26].
- rs  input  5  source register.
- rt  input  5  target register.
- rd  input  5  destination register.
- shamt  input  5  shift amount.
- func  input  6  R-type function code.
- imm  input  16  I-type immediate.
- target  input  26  J-type target.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  packed instruction word.
- word_count  output  ADDR_W+1  words written this session.
- done  output  1  session complete.
- full  output  1  session ended because DEPTH was reached.
- err  output  1  sticky illegal-bundle flag (only with ENC_CHECK_EN).

Behaviour:
- Reset state: IDLE.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0.
  - done=0, full=0, err=0.
  - in_ready=0 while reset is asserted.
- State machine: IDLE -> ENCODE -> WRITE -> (IDLE | DONE).
- in_ready = (state==IDLE) && !reset. It is a combinational decode of state only.
- IDLE: on in_valid && in_ready, capture all fields plus in_last into holding registers, then go to ENCODE. Otherwise stay in IDLE.
- ENCODE: register mem_wdata from the captured fields.
  - R: {opcode,rs,rt,rd,shamt,func}
  - I: {opcode,rs,rt,imm}
  - J: {opcode,target}
  - raw: {opcode,26'b0}
  - Go to WRITE.
- WRITE: mem_we=1 for exactly this one cycle, with the current mem_addr and mem_wdata.
  - On exit: mem_addr+1 and word_count+1.
  - If the captured last==1, go to DONE.
  - Else if the new word_count==DEPTH, set full=1 and go to DONE.
  - Else go to IDLE.
- Latency: handshake in cycle N -> mem_we high in cycle N+2 -> in_ready high again in cycle N+3. Peak throughput is one word per 3 cycles.
- DONE: done=1, in_ready=0, mem_we=0. Input bundles are ignored.
  - start: clear done, full and word_count; set mem_addr=BASE_ADDR; go to IDLE.
- start outside DONE: ignored.
- mem_addr wrap: increments modulo 2^ADDR_W. With BASE_ADDR+DEPTH > 2^ADDR_W the address wraps to 0; this is legal but the integrator must avoid it.
- last and DEPTH reached on the same word: full=1 and done=1.
- Reset mid-session (any state): the word in flight is abandoned, mem_we is not asserted, and all registers return to reset values.
- Field bits not used by the selected fmt are ignored.

Optional Feature:
- Macro: ENC_CHECK_EN.
- Defined:
  - A bundle is illegal if fmt==0 with opcode!=0, or fmt==3.
  - An illegal bundle is accepted by the handshake, then goes ENCODE -> IDLE with no write. mem_addr and word_count are unchanged.
  - err is set and stays set until reset or start.
  - An illegal bundle with in_last=1 still moves to DONE.
- Undefined:
  - No check is performed; fmt 0 and fmt 3 encode as described above.
  - err is tied to 0.

Test Plan:
- R-type add $1,$2,$3 (fmt=0, opcode=0, rs=2, rt=3, rd=1, shamt=0, func=0x20) after reset -> mem_we one cycle at N+2, mem_addr=0x00, mem_wdata=0x00430820, word_count=1.
- I-type lw $8,4($9) (fmt=1, opcode=0x23, rs=9, rt=8, imm=0x0004) as the second word -> mem_addr=0x01, mem_wdata=0x8D280004.
- J-type j (fmt=2, opcode=2, target=0x0100000) with in_last=1 -> mem_wdata=0x08100000. done=1 the cycle after WRITE; in_ready=0 until start, then mem_addr=BASE_ADDR.
- DEPTH=4, four words with in_last=0 streamed with in_valid held high -> exactly four mem_we pulses at addresses 0..3, full=1, done=1, fifth bundle not accepted.
- Reset asserted in ENCODE -> no mem_we. Next cycle: in_ready=0 while reset is held, all outputs at reset values; after release, the next word is written at BASE_ADDR.
- ENC_CHECK_EN defined: fmt=0 with opcode=0x08 -> no mem_we, err=1, mem_addr unchanged. A following legal word is written at the same address.
